uart_frame_parser: RTL

//   Byte-stream framer directly downstream of the UART receiver: consumes each received

---
 rtl/uart_frame_parser.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser downstream of a UART receiver: SOF, LEN, payload, check byte.
// Only validated payloads are replayed on a valid/ready stream. Define UART_FRAME_CRC8_EN for a CRC-8 check byte.
module uart_frame_parser #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF         = 8'hA5,
   parameter int         TIMEOUT_CYC = 4096,
   parameter int         LW          = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx_done_tick,
   input  logic [7:0]    din,
   output logic          frame_valid,
   input  logic          frame_ready,
   output logic [7:0]    frame_data,
   output logic          frame_last,
   output logic [LW-1:0] frame_len,
   output logic          err_len,
   output logic          err_chk,
   output logic          err_timeout,
   output logic          overrun,
   output logic          busy
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

   state_t        state, state_next;
   logic [LW-1:0] len;
   logic [7:0]    chk;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [TW-1:0] timer;
   logic [7:0]    payload_mem [MAX_LEN];

   logic len_bad, last_wr, last_rd, timeout_hit, handshake;
   logic set_err_len, set_err_chk, set_err_timeout, set_overrun;

   // One byte of running check: XOR, or CRC-8 poly 0x07 unrolled over 8 bit steps.
   function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] d);
`ifdef UART_FRAME_CRC8_EN
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++)
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
`else
      return c ^ d;
`endif
   endfunction

   assign len_bad     = (din == 8'h00) || (int'(din) > MAX_LEN);
   assign last_wr     = (LW'(wr_idx) == len - LW'(1));
   assign last_rd     = (LW'(rd_idx) == len - LW'(1));
   assign timeout_hit = (timer == TW'(TIMEOUT_CYC - 1));
   assign handshake   = frame_valid & frame_ready;

   assign frame_valid = (state == S_EMIT);
   assign frame_data  = frame_valid ? payload_mem[rd_idx] : 8'h00;
   assign frame_last  = frame_valid & last_rd;
   assign frame_len   = frame_valid ? len : '0;
   assign busy        = (state != S_HUNT);

   // NOTE: every always_comb output gets a default before the case so no path infers a latch.
   always_comb begin
      state_next      = state;
      set_err_len     = 1'b0;
      set_err_chk     = 1'b0;
      set_err_timeout = 1'b0;
      set_overrun     = 1'b0;
      case (state)
         S_HUNT:
            if (rx_done_tick && din == SOF) state_next = S_LEN;
         S_LEN:
            if (rx_done_tick) begin
               if (len_bad) begin
                  set_err_len = 1'b1;
                  state_next  = S_HUNT;
               end else begin
                  state_next  = S_PAYLOAD;
               end
            end else if (timeout_hit) begin
               set_err_timeout = 1'b1;
               state_next      = S_HUNT;
            end
         S_PAYLOAD:
            if (rx_done_tick) begin
               if (last_wr) state_next = S_CHK;
            end else if (timeout_hit) begin
               set_err_timeout = 1'b1;
               state_next      = S_HUNT;
            end
         S_CHK:
            if (rx_done_tick) begin
               if (din == chk) begin
                  state_next  = S_EMIT;
               end else begin
                  set_err_chk = 1'b1;
                  state_next  = S_HUNT;
               end
            end else if (timeout_hit) begin
               set_err_timeout = 1'b1;
               state_next      = S_HUNT;
            end
         S_EMIT: begin
            set_overrun = rx_done_tick;
            if (handshake && last_rd) state_next = S_HUNT;
         end
         default: state_next = S_HUNT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_HUNT;
         len         <= '0;
         chk         <= 8'h00;
         wr_idx      <= '0;
         rd_idx      <= '0;
         timer       <= '0;
         err_len     <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_next;
         err_len     <= set_err_len;
         err_chk     <= set_err_chk;
         err_timeout <= set_err_timeout;
         overrun     <= set_overrun;

         // Inter-byte timer only runs while a frame is being collected.
         if (!rx_done_tick && !timeout_hit &&
             (state == S_LEN || state == S_PAYLOAD || state == S_CHK))
            timer <= timer + 1'b1;
         else
            timer <= '0;

         if (state == S_LEN && rx_done_tick && !len_bad) begin
            len    <= LW'(din);
            chk    <= chk_step(8'h00, din);
            wr_idx <= '0;
         end
         if (state == S_PAYLOAD && rx_done_tick) begin
            chk <= chk_step(chk, din);
            if (!last_wr) wr_idx <= wr_idx + 1'b1;
         end
         if (state == S_CHK && rx_done_tick) rd_idx <= '0;
         if (handshake && !last_rd) rd_idx <= rd_idx + 1'b1;
      end
   end

   // NOTE: payload storage is deliberately not reset; it is only read after being written for the current frame.
   always_ff @(posedge clk) begin
      if (state == S_PAYLOAD && rx_done_tick) payload_mem[wr_idx] <= din;
   end

endmodule
